// File: rtl/vend_session_ctrl.sv
// Vending session controller: coin credit, product selection, dispense handshake
// with acknowledge timeout, idle auto-refund and tick-paced change return.
module vend_session_ctrl #(
  parameter int TICK_DIV     = 10_000_000,
  parameter int PRICE0       = 3,
  parameter int PRICE1       = 4,
  parameter int PRICE2       = 5,
  parameter int PRICE3       = 6,
  parameter int CREDIT_MAX   = 14,
  parameter int ACK_TIMEOUT  = 10,
  parameter int IDLE_TIMEOUT = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_half,
  input  logic       coin_one,
  input  logic       sel_valid,
  input  logic [1:0] sel_id,
  input  logic       cancel,
  input  logic       disp_ack,
  output logic       disp_req,
  output logic [1:0] disp_id,
  output logic       change_pulse,
  output logic       coin_reject,
  output logic       sel_deny,
  output logic [3:0] credit,
  output logic [1:0] state,
  output logic       busy,
  output logic       fault
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CREDIT = 2'd1,
    S_VEND   = 2'd2,
    S_RETURN = 2'd3
  } state_t;

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  localparam int AW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [IW-1:0] IDLE_LAST  = IW'(IDLE_TIMEOUT - 1);
  localparam logic [AW-1:0] ACK_LAST   = AW'(ACK_TIMEOUT - 1);
  localparam logic [4:0]    CREDIT_LIM = 5'(CREDIT_MAX);

  state_t        state_reg, state_next;
  logic [3:0]    credit_reg, credit_next;
  logic [3:0]    price_reg, price_next;
  logic          disp_req_reg, disp_req_next;
  logic [1:0]    disp_id_reg, disp_id_next;
  logic          change_reg, change_next;
  logic          reject_reg, reject_next;
  logic          deny_reg, deny_next;
  logic          fault_reg, fault_next;
  logic          busy_reg;
  logic [TW-1:0] tick_cnt_reg;
  logic [IW-1:0] idle_cnt_reg, idle_cnt_next;
  logic [AW-1:0] ack_cnt_reg, ack_cnt_next;

  logic       tick;
  logic       coin_any;
  logic [4:0] credit_plus;
  logic       coin_ok;
  logic [3:0] sel_price;

  function automatic logic [3:0] price_of(input logic [1:0] id);
    case (id)
      2'd0:    price_of = 4'(PRICE0);
      2'd1:    price_of = 4'(PRICE1);
      2'd2:    price_of = 4'(PRICE2);
      default: price_of = 4'(PRICE3);
    endcase
  endfunction

  assign tick        = (tick_cnt_reg == TICK_LAST);
  assign coin_any    = coin_half | coin_one;
  assign credit_plus = {1'b0, credit_reg} + {4'b0, coin_half} + {3'b0, coin_one, 1'b0};
  assign coin_ok     = (credit_plus <= CREDIT_LIM);
  assign sel_price   = price_of(sel_id);

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_reg <= '0;
      state_reg    <= S_IDLE;
      credit_reg   <= '0;
      price_reg    <= '0;
      disp_req_reg <= 1'b0;
      disp_id_reg  <= '0;
      change_reg   <= 1'b0;
      reject_reg   <= 1'b0;
      deny_reg     <= 1'b0;
      fault_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      idle_cnt_reg <= '0;
      ack_cnt_reg  <= '0;
    end else begin
      tick_cnt_reg <= tick ? '0 : tick_cnt_reg + 1'b1;
      state_reg    <= state_next;
      credit_reg   <= credit_next;
      price_reg    <= price_next;
      disp_req_reg <= disp_req_next;
      disp_id_reg  <= disp_id_next;
      change_reg   <= change_next;
      reject_reg   <= reject_next;
      deny_reg     <= deny_next;
      fault_reg    <= fault_next;
      busy_reg     <= state_next[1];
      idle_cnt_reg <= idle_cnt_next;
      ack_cnt_reg  <= ack_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    credit_next   = credit_reg;
    price_next    = price_reg;
    disp_req_next = disp_req_reg;
    disp_id_next  = disp_id_reg;
    fault_next    = fault_reg;
    idle_cnt_next = idle_cnt_reg;
    ack_cnt_next  = ack_cnt_reg;
    change_next   = 1'b0;
    reject_next   = 1'b0;
    deny_next     = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (coin_any) begin
          if (!fault_reg && coin_ok) begin
            credit_next   = credit_plus[3:0];
            idle_cnt_next = '0;
            state_next    = S_CREDIT;
          end else begin
            reject_next = 1'b1;
          end
        end
      end

      S_CREDIT: begin
        if (cancel) begin
          reject_next = coin_any;
          state_next  = S_RETURN;
        end else if (sel_valid && (credit_reg >= sel_price)) begin
          credit_next   = credit_reg - sel_price;
          price_next    = sel_price;
          disp_id_next  = sel_id;
          disp_req_next = 1'b1;
          ack_cnt_next  = '0;
          reject_next   = coin_any;
          state_next    = S_VEND;
        end else begin
          // A denied selection still lets same-cycle coins through.
          deny_next = sel_valid;
          if (coin_any) begin
            if (coin_ok) credit_next = credit_plus[3:0];
            else         reject_next = 1'b1;
          end
        end
        if (coin_any || sel_valid || cancel) begin
          idle_cnt_next = '0;
        end else if (tick) begin
          if (idle_cnt_reg == IDLE_LAST) begin
            idle_cnt_next = '0;
            state_next    = S_RETURN;
          end else begin
            idle_cnt_next = idle_cnt_reg + 1'b1;
          end
        end
      end

      S_VEND: begin
        reject_next = coin_any;
        if (disp_ack) begin
          disp_req_next = 1'b0;
          state_next    = (credit_reg != 4'd0) ? S_RETURN : S_IDLE;
        end else if (tick) begin
          if (ack_cnt_reg == ACK_LAST) begin
            // Dispenser never answered: refund the full price and latch the fault.
            disp_req_next = 1'b0;
            credit_next   = credit_reg + price_reg;
            fault_next    = 1'b1;
            state_next    = S_RETURN;
          end else begin
            ack_cnt_next = ack_cnt_reg + 1'b1;
          end
        end
      end

      default: begin
        reject_next = coin_any;
        if (credit_reg == 4'd0) begin
          state_next = S_IDLE;
        end else if (tick) begin
          change_next = 1'b1;
          credit_next = credit_reg - 4'd1;
        end
      end
    endcase
  end

  assign disp_req     = disp_req_reg;
  assign disp_id      = disp_id_reg;
  assign change_pulse = change_reg;
  assign coin_reject  = reject_reg;
  assign sel_deny     = deny_reg;
  assign credit       = credit_reg;
  assign state        = state_reg;
  assign busy         = busy_reg;
  assign fault        = fault_reg;

endmodule

// File: tb/tb_vend_session_ctrl.sv
// Directed testbench for vend_session_ctrl with shortened tick and timeouts.
module tb_vend_session_ctrl;

  localparam int TD = 4;
  localparam int AT = 3;
  localparam int IT = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       coin_half = 1'b0;
  logic       coin_one = 1'b0;
  logic       sel_valid = 1'b0;
  logic [1:0] sel_id = 2'd0;
  logic       cancel = 1'b0;
  logic       disp_ack = 1'b0;
  logic       disp_req;
  logic [1:0] disp_id;
  logic       change_pulse;
  logic       coin_reject;
  logic       sel_deny;
  logic [3:0] credit;
  logic [1:0] state;
  logic       busy;
  logic       fault;

  int n_checks = 0;
  int n_fail = 0;

  vend_session_ctrl #(
    .TICK_DIV(TD), .PRICE0(3), .PRICE1(4), .PRICE2(5), .PRICE3(6),
    .CREDIT_MAX(14), .ACK_TIMEOUT(AT), .IDLE_TIMEOUT(IT)
  ) dut (
    .clk(clk), .rst(rst), .coin_half(coin_half), .coin_one(coin_one),
    .sel_valid(sel_valid), .sel_id(sel_id), .cancel(cancel), .disp_ack(disp_ack),
    .disp_req(disp_req), .disp_id(disp_id), .change_pulse(change_pulse),
    .coin_reject(coin_reject), .sel_deny(sel_deny), .credit(credit),
    .state(state), .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic coin(input logic h, input logic o);
    coin_half = h; coin_one = o;
    step();
    coin_half = 1'b0; coin_one = 1'b0;
    $display("coin half=%0b one=%0b -> credit %0d state %0d reject %0b", h, o, credit, state, coin_reject);
  endtask

  task automatic select(input logic [1:0] id);
    sel_valid = 1'b1; sel_id = id;
    step();
    sel_valid = 1'b0;
    $display("select id=%0d -> credit %0d state %0d deny %0b req %0b", id, credit, state, sel_deny, disp_req);
  endtask

  task automatic do_cancel();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    $display("cancel -> state %0d credit %0d", state, credit);
  endtask

  task automatic ack();
    disp_ack = 1'b1;
    step();
    disp_ack = 1'b0;
    $display("ack -> state %0d credit %0d req %0b", state, credit, disp_req);
  endtask

  task automatic drain(input int max_cyc, output int cnt, output int min_gap);
    int last;
    int cyc;
    cnt = 0; min_gap = 1000; last = -1; cyc = 0;
    while (state !== 2'd0 && cyc < max_cyc) begin
      step();
      cyc++;
      if (change_pulse === 1'b1) begin
        cnt++;
        if (last >= 0 && (cyc - last) < min_gap) min_gap = cyc - last;
        last = cyc;
      end
    end
    $display("drain -> %0d change pulses, state %0d credit %0d", cnt, state, credit);
  endtask

  task automatic test_reset();
    coin_one = 1'b1; sel_valid = 1'b1; cancel = 1'b1;
    do_reset();
    coin_one = 1'b0; sel_valid = 1'b0; cancel = 1'b0;
    step();
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state); end
    n_checks++; if (credit !== 4'd0) begin n_fail++; $display("FAIL reset_credit: got %0d expected 0", credit); end
    n_checks++; if ({disp_req, disp_id, change_pulse, coin_reject, sel_deny, busy, fault} !== 8'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected 00000000", {disp_req, disp_id, change_pulse, coin_reject, sel_deny, busy, fault});
    end
  endtask

  task automatic test_vend_ack();
    int cnt, gap;
    coin(1'b0, 1'b1);
    n_checks++; if (state !== 2'd1 || credit !== 4'd2) begin n_fail++; $display("FAIL vend_first_coin: got state %0d credit %0d expected 1/2", state, credit); end
    coin(1'b0, 1'b1);
    n_checks++; if (credit !== 4'd4) begin n_fail++; $display("FAIL vend_credit4: got %0d expected 4", credit); end
    select(2'd0);
    n_checks++; if (credit !== 4'd1 || disp_req !== 1'b1 || disp_id !== 2'd0 || state !== 2'd2 || busy !== 1'b1) begin
      n_fail++; $display("FAIL vend_accept: got credit %0d req %0b id %0d state %0d busy %0b expected 1/1/0/2/1", credit, disp_req, disp_id, state, busy);
    end
    ack();
    n_checks++; if (disp_req !== 1'b0 || state !== 2'd3) begin n_fail++; $display("FAIL vend_ack: got req %0b state %0d expected 0/3", disp_req, state); end
    drain(100, cnt, gap);
    n_checks++; if (cnt != 1 || state !== 2'd0 || credit !== 4'd0) begin n_fail++; $display("FAIL vend_change: got %0d pulses state %0d expected 1 pulse state 0", cnt, state); end
  endtask

  task automatic test_deny();
    int cnt, gap;
    coin(1'b1, 1'b0);
    select(2'd3);
    n_checks++; if (sel_deny !== 1'b1 || credit !== 4'd1 || state !== 2'd1 || disp_req !== 1'b0) begin
      n_fail++; $display("FAIL deny_pulse: got deny %0b credit %0d state %0d req %0b expected 1/1/1/0", sel_deny, credit, state, disp_req);
    end
    step();
    n_checks++; if (sel_deny !== 1'b0) begin n_fail++; $display("FAIL deny_one_cycle: got %0b expected 0", sel_deny); end
    do_cancel();
    n_checks++; if (state !== 2'd3) begin n_fail++; $display("FAIL deny_cancel: got state %0d expected 3", state); end
    drain(100, cnt, gap);
    n_checks++; if (cnt != 1 || state !== 2'd0) begin n_fail++; $display("FAIL deny_refund: got %0d pulses expected 1", cnt); end
  endtask

  task automatic test_ceiling();
    int cnt, gap;
    for (int i = 0; i < 6; i++) coin(1'b0, 1'b1);
    coin(1'b1, 1'b0);
    n_checks++; if (credit !== 4'd13) begin n_fail++; $display("FAIL ceil_13: got %0d expected 13", credit); end
    coin(1'b1, 1'b1);
    n_checks++; if (coin_reject !== 1'b1 || credit !== 4'd13) begin n_fail++; $display("FAIL ceil_both_reject: got reject %0b credit %0d expected 1/13", coin_reject, credit); end
    coin(1'b1, 1'b0);
    n_checks++; if (coin_reject !== 1'b0 || credit !== 4'd14) begin n_fail++; $display("FAIL ceil_14: got reject %0b credit %0d expected 0/14", coin_reject, credit); end
    coin(1'b1, 1'b0);
    n_checks++; if (coin_reject !== 1'b1 || credit !== 4'd14) begin n_fail++; $display("FAIL ceil_over: got reject %0b credit %0d expected 1/14", coin_reject, credit); end
    do_cancel();
    drain(200, cnt, gap);
    n_checks++; if (cnt != 14 || gap != TD || state !== 2'd0) begin n_fail++; $display("FAIL ceil_refund: got %0d pulses gap %0d expected 14 gap %0d", cnt, gap, TD); end
  endtask

  task automatic test_ack_timeout();
    int cnt, gap, cyc;
    for (int i = 0; i < 3; i++) coin(1'b0, 1'b1);
    select(2'd2);
    n_checks++; if (credit !== 4'd1 || disp_id !== 2'd2 || state !== 2'd2) begin n_fail++; $display("FAIL to_accept: got credit %0d id %0d state %0d expected 1/2/2", credit, disp_id, state); end
    coin(1'b1, 1'b0);
    n_checks++; if (coin_reject !== 1'b1 || credit !== 4'd1) begin n_fail++; $display("FAIL to_coin_in_vend: got reject %0b credit %0d expected 1/1", coin_reject, credit); end
    do_cancel();
    n_checks++; if (state !== 2'd2 || disp_req !== 1'b1) begin n_fail++; $display("FAIL to_cancel_ignored: got state %0d req %0b expected 2/1", state, disp_req); end
    cyc = 0;
    while (fault !== 1'b1 && cyc < 100) begin step(); cyc++; end
    n_checks++; if (fault !== 1'b1 || credit !== 4'd6 || state !== 2'd3 || disp_req !== 1'b0) begin
      n_fail++; $display("FAIL to_fault: got fault %0b credit %0d state %0d req %0b expected 1/6/3/0", fault, credit, state, disp_req);
    end
    drain(200, cnt, gap);
    n_checks++; if (cnt != 6 || gap != TD || state !== 2'd0) begin n_fail++; $display("FAIL to_refund: got %0d pulses gap %0d expected 6 gap %0d", cnt, gap, TD); end
    coin(1'b0, 1'b1);
    n_checks++; if (coin_reject !== 1'b1 || credit !== 4'd0 || state !== 2'd0 || fault !== 1'b1) begin
      n_fail++; $display("FAIL to_fault_sticky: got reject %0b credit %0d state %0d fault %0b expected 1/0/0/1", coin_reject, credit, state, fault);
    end
    do_reset();
    n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL to_fault_clear: got %0b expected 0", fault); end
  endtask

  task automatic test_idle_timeout();
    int cnt, gap, cyc;
    coin(1'b1, 1'b1);
    n_checks++; if (credit !== 4'd3 || state !== 2'd1 || coin_reject !== 1'b0) begin n_fail++; $display("FAIL idle_sum: got credit %0d state %0d expected 3/1", credit, state); end
    cyc = 0;
    while (state !== 2'd3 && cyc < 100) begin step(); cyc++; end
    n_checks++; if (state !== 2'd3 || cyc < (IT - 1) * TD + 1 || cyc > IT * TD || credit !== 4'd3) begin
      n_fail++; $display("FAIL idle_timeout: got state %0d after %0d cycles credit %0d expected 3 within %0d..%0d credit 3", state, cyc, credit, (IT - 1) * TD + 1, IT * TD);
    end
    drain(100, cnt, gap);
    n_checks++; if (cnt != 3 || state !== 2'd0) begin n_fail++; $display("FAIL idle_refund: got %0d pulses expected 3", cnt); end
  endtask

  task automatic test_ignored();
    select(2'd0);
    n_checks++; if (sel_deny !== 1'b0 || state !== 2'd0 || disp_req !== 1'b0) begin n_fail++; $display("FAIL ign_sel: got deny %0b state %0d req %0b expected 0/0/0", sel_deny, state, disp_req); end
    do_cancel();
    n_checks++; if (state !== 2'd0 || change_pulse !== 1'b0) begin n_fail++; $display("FAIL ign_cancel: got state %0d change %0b expected 0/0", state, change_pulse); end
  endtask

  task automatic test_back_to_back();
    int cnt, gap;
    coin(1'b0, 1'b1);
    coin(1'b0, 1'b1);
    select(2'd1);
    n_checks++; if (credit !== 4'd0 || state !== 2'd2) begin n_fail++; $display("FAIL b2b_accept: got credit %0d state %0d expected 0/2", credit, state); end
    ack();
    n_checks++; if (state !== 2'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got state %0d busy %0b expected 0/0", state, busy); end
    coin(1'b1, 1'b0);
    n_checks++; if (credit !== 4'd1 || state !== 2'd1) begin n_fail++; $display("FAIL b2b_coin: got credit %0d state %0d expected 1/1", credit, state); end
    do_cancel();
    drain(100, cnt, gap);
    n_checks++; if (cnt != 1) begin n_fail++; $display("FAIL b2b_refund: got %0d pulses expected 1", cnt); end
  endtask

  task automatic test_rst_return();
    int cnt;
    coin(1'b0, 1'b1);
    coin(1'b0, 1'b1);
    coin(1'b1, 1'b0);
    do_cancel();
    n_checks++; if (state !== 2'd3 || credit !== 4'd5) begin n_fail++; $display("FAIL rr_return: got state %0d credit %0d expected 3/5", state, credit); end
    do_reset();
    n_checks++; if (state !== 2'd0 || credit !== 4'd0) begin n_fail++; $display("FAIL rr_reset: got state %0d credit %0d expected 0/0", state, credit); end
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (change_pulse === 1'b1) cnt++;
    end
    $display("post-reset watch -> %0d change pulses, state %0d", cnt, state);
    n_checks++; if (cnt != 0 || state !== 2'd0) begin n_fail++; $display("FAIL rr_no_change: got %0d pulses state %0d expected 0/0", cnt, state); end
  endtask

  initial begin
    test_reset();
    test_vend_ack();
    test_deny();
    test_ceiling();
    test_ack_timeout();
    test_idle_timeout();
    test_ignored();
    test_back_to_back();
    test_rst_return();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vend_session_ctrl.md
VEND_SESSION_CTRL -- requirements
Module: vend_session_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 10_000_000, clk cycles per time tick (0.2 s at 50 MHz).
REQ-002 Parameter PRICE0/PRICE1/PRICE2/PRICE3, defaults 3/4/5/6, product prices in half-units (1.5/2.0/2.5/3.0).
REQ-003 Parameter CREDIT_MAX, default 14, credit ceiling in half-units (7.0).
REQ-004 Parameter ACK_TIMEOUT, default 10, ticks allowed for dispenser acknowledge.
REQ-005 Parameter IDLE_TIMEOUT, default 50, ticks of inactivity in CREDIT before auto-refund.
REQ-006 clk  input  1  system clock; one clock domain; all logic on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 coin_half  input  1  one-cycle pulse, 0.5 coin inserted (+1 half-unit).
REQ-009 coin_one  input  1  one-cycle pulse, 1.0 coin inserted (+2 half-units).
REQ-010 sel_valid  input  1  one-cycle pulse, product selection.
REQ-011 sel_id  input  2  product index, sampled when sel_valid=1.
REQ-012 cancel  input  1  one-cycle pulse, refund request.
REQ-013 disp_ack  input  1  dispenser acknowledge, level.
REQ-014 disp_req  output  1  dispense request, held until ack or timeout.
REQ-015 disp_id  output  2  product index latched at accepted selection.
REQ-016 change_pulse  output  1  one-cycle pulse per half-unit returned.
REQ-017 coin_reject  output  1  one-cycle pulse, coin(s) refused.
REQ-018 sel_deny  output  1  one-cycle pulse, selection refused for insufficient credit.
REQ-019 credit  output  4  current credit, half-units.
REQ-020 state  output  2  FSM state: 0 IDLE, 1 CREDIT, 2 VEND, 3 RETURN.
REQ-021 busy  output  1  high in VEND or RETURN.
REQ-022 fault  output  1  sticky dispenser-timeout flag.

Function
REQ-023 Tick: free-running counter 0..TICK_DIV-1; internal tick strobe one cycle when counter = TICK_DIV-1, then wraps to 0.
REQ-024 All outputs registered; an input event sampled at edge N is reflected in outputs after edge N (one-cycle latency).
REQ-025 Coins accepted only in IDLE (fault=0) or CREDIT; same-cycle coin_half+coin_one summed (+3); if credit+sum > CREDIT_MAX, all coins that cycle rejected and credit unchanged.
REQ-026 Coin in VEND, RETURN, or while fault=1 -> coin_reject, credit unchanged.
REQ-027 IDLE: credit=0; accepted coin -> CREDIT.
REQ-028 CREDIT priority per cycle: cancel > sel_valid > coins; coins in the same cycle as a cancel or an accepted selection are rejected.
REQ-029 CREDIT, cancel -> RETURN.
REQ-030 CREDIT, sel_valid with credit >= PRICE[sel_id] -> credit -= price, disp_id latched, disp_req=1, -> VEND.
REQ-031 CREDIT, sel_valid with credit < price -> sel_deny pulse, stay in CREDIT, credit unchanged.
REQ-032 CREDIT idle timer counts ticks, cleared by any coin/sel_valid/cancel; reaching IDLE_TIMEOUT -> RETURN.
REQ-033 VEND: disp_ack sampled high -> disp_req=0 next cycle; -> RETURN if credit>0, else IDLE.
REQ-034 VEND: ACK_TIMEOUT ticks without ack -> disp_req=0, price restored to credit, fault=1, -> RETURN.
REQ-035 RETURN: on each tick with credit>0, change_pulse for one cycle and credit -= 1; credit=0 -> IDLE.
REQ-036 sel_valid/cancel outside CREDIT ignored, no pulses.
REQ-037 fault cleared only by rst; while set, the block completes the refund then stays in IDLE.

Reset
REQ-038 rst=1 at an edge: state=IDLE, credit=0, all pulse outputs 0, disp_req=0, disp_id=0, fault=0, tick, idle and ack timers=0, overriding all inputs.
REQ-039 rst mid-VEND or mid-RETURN abandons the session; no remaining credit is returned.

Verification
REQ-040 coin_one x2, sel_valid sel_id=0 -> credit 4->1, disp_req=1, disp_id=0; ack -> RETURN, one change_pulse, IDLE.
REQ-041 coin_half, sel_valid sel_id=3 -> sel_deny pulse, credit stays 1, state CREDIT.
REQ-042 credit=13, coin_half+coin_one same cycle -> coin_reject, credit 13; then coin_half -> credit 14.
REQ-043 credit=6, sel_id=2, no ack for ACK_TIMEOUT ticks -> fault=1, credit 6, six change_pulses one per tick, IDLE.
REQ-044 credit=3, no activity for IDLE_TIMEOUT ticks -> RETURN, three change_pulses, IDLE.
REQ-045 rst asserted during RETURN with credit 5 -> next cycle state 0, credit 0, no further change_pulse.
